// File: rtl/frame_drain_pkg.sv
// Shared definitions for the trace frame drain: FSM encoding, frame geometry
// and the TPIU full-sync pattern.
package frame_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_SEND_LO,
    ST_SEND_HI,
    ST_SETTLE_W,
    ST_ABORT
  } state_e;

  localparam int         WORDS_PER_FRAME = 8;
  localparam int         SYNC_LEN        = 4;
  localparam logic [7:0] SYNC_BYTE_FF    = 8'hFF;
  localparam logic [7:0] SYNC_BYTE_LAST  = 8'h7F;

  // Byte idx of the full-sync pattern: three 0xFF then 0x7F.
  function automatic logic [7:0] sync_byte(input logic [1:0] idx);
    return (idx == 2'(SYNC_LEN - 1)) ? SYNC_BYTE_LAST : SYNC_BYTE_FF;
  endfunction

endpackage

// File: rtl/frame_drain_byte_hold.sv
// Single-entry valid/ready output register for the byte stream; a flush drops
// the held byte without completing its handshake.
module byte_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       flush_i,
  input  logic       ready_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       accept_o
);

  logic [7:0] byte_q;
  logic       valid_q;

  assign accept_o = valid_q & ready_i;
  assign byte_o   = byte_q;
  assign valid_o  = valid_q;

  // A load in the same cycle as an acceptance replaces the outgoing byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      byte_q  <= data_i;
      valid_q <= 1'b1;
    end else if (accept_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_drain.sv
// Pulls complete 8-word frames from the trace frame buffer and serialises them
// low byte first, with periodic TPIU sync and abort/rewind support.
module frame_drain
  import frame_drain_pkg::*;
#(
  parameter int SYNC_INTERVAL = 16,
  parameter int SETTLE        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DataVal,
  input  logic        DataReady,
  input  logic        FrameReady,
  output logic        DataNext,
  output logic        DataFrameReset,
  input  logic        Abort,
  output logic [7:0]  TxByte,
  output logic        TxValid,
  input  logic        TxReady,
  output logic        Busy,
  output logic [15:0] FramesSent
);

  localparam logic [15:0] SYNC_IV   = 16'(SYNC_INTERVAL);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE);
  localparam logic [3:0]  LAST_IDX  = 4'(WORDS_PER_FRAME);

  state_e      state_q, state_d;
  logic [7:0]  word_hi_q, word_hi_d;
  logic [7:0]  settle_q, settle_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  sync_idx_q, sync_idx_d;
  logic [15:0] fss_q, fss_d;
  logic [15:0] frames_q, frames_d;
  logic        dnext_q, dfr_q, busy_q;

  logic        hold_load, hold_flush, tx_accept;
  logic [7:0]  hold_data;
  logic        final_accept, abort_take;

  // FrameReady already guarantees a whole frame, so the word-level flag is not needed.
  logic unused_inputs;
  assign unused_inputs = DataReady;

  byte_hold u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hold_load),
    .data_i   (hold_data),
    .flush_i  (hold_flush),
    .ready_i  (TxReady),
    .byte_o   (TxByte),
    .valid_o  (TxValid),
    .accept_o (tx_accept)
  );

  assign final_accept = (state_q == ST_SEND_HI) && tx_accept && (idx_q == LAST_IDX);
  assign abort_take   = Abort && (state_q != ST_IDLE) && (state_q != ST_ABORT) && !final_accept;

  always_comb begin
    state_d    = state_q;
    word_hi_d  = word_hi_q;
    settle_d   = (settle_q != 8'd0) ? settle_q - 8'd1 : 8'd0;
    idx_d      = idx_q;
    sync_idx_d = sync_idx_q;
    fss_d      = fss_q;
    frames_d   = frames_q;
    hold_load  = 1'b0;
    hold_data  = 8'h00;
    hold_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (FrameReady && !Abort) begin
          idx_d = 4'd0;
          if ((SYNC_IV != 16'd0) && (fss_q >= SYNC_IV)) begin
            state_d    = ST_SYNC;
            sync_idx_d = 2'd0;
            hold_load  = 1'b1;
            hold_data  = sync_byte(2'd0);
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_SYNC: begin
        if (tx_accept) begin
          if (sync_idx_q == 2'(SYNC_LEN - 1)) begin
            state_d = ST_LOAD;
            fss_d   = 16'd0;
          end else begin
            sync_idx_d = sync_idx_q + 2'd1;
            hold_load  = 1'b1;
            hold_data  = sync_byte(sync_idx_q + 2'd1);
          end
        end
      end
      ST_LOAD: begin
        // Low byte goes straight to the output register; only the high byte is kept.
        word_hi_d = DataVal[15:8];
        hold_load = 1'b1;
        hold_data = DataVal[7:0];
        settle_d  = SETTLE_LD;
        idx_d     = idx_q + 4'd1;
        state_d   = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (tx_accept) begin
          hold_load = 1'b1;
          hold_data = word_hi_q;
          state_d   = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (tx_accept) begin
          if (idx_q == LAST_IDX) begin
            frames_d = frames_q + 16'd1;
            if (fss_q < SYNC_IV) fss_d = fss_q + 16'd1;
            state_d = ST_IDLE;
          end else if (settle_q == 8'd0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_SETTLE_W;
          end
        end
      end
      ST_SETTLE_W: begin
        // Counter reaches zero this cycle, so the next cycle may capture.
        if (settle_q <= 8'd1) state_d = ST_LOAD;
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_take) begin
      state_d    = ST_ABORT;
      hold_load  = 1'b0;
      hold_flush = 1'b1;
      fss_d      = fss_q;
      frames_d   = frames_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_hi_q  <= 8'h00;
      settle_q   <= 8'd0;
      idx_q      <= 4'd0;
      sync_idx_q <= 2'd0;
      fss_q      <= SYNC_IV;
      frames_q   <= 16'd0;
      dnext_q    <= 1'b0;
      dfr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_hi_q  <= word_hi_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      sync_idx_q <= sync_idx_d;
      fss_q      <= fss_d;
      frames_q   <= frames_d;
      dnext_q    <= (state_d == ST_LOAD);
      dfr_q      <= (state_d == ST_ABORT);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign DataNext       = dnext_q;
  assign DataFrameReset = dfr_q;
  assign Busy           = busy_q;
  assign FramesSent     = frames_q;

endmodule

// File: tb/tb_frame_drain.sv
// Randomised bench for frame_drain: a frame-buffer model feeds the DUT and a
// scoreboard checks the byte stream against a frame-level reference model.
module tb_frame_drain;

  localparam int SYNC_INTERVAL = 16;
  localparam int SETTLE        = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataVal;
  logic        DataReady, FrameReady, DataNext, DataFrameReset, Abort;
  logic [7:0]  TxByte;
  logic        TxValid, TxReady, Busy;
  logic [15:0] FramesSent;

  frame_drain #(.SYNC_INTERVAL(SYNC_INTERVAL), .SETTLE(SETTLE)) dut (
    .clk            (clk),
    .rst            (rst),
    .DataVal        (DataVal),
    .DataReady      (DataReady),
    .FrameReady     (FrameReady),
    .DataNext       (DataNext),
    .DataFrameReset (DataFrameReset),
    .Abort          (Abort),
    .TxByte         (TxByte),
    .TxValid        (TxValid),
    .TxReady        (TxReady),
    .Busy           (Busy),
    .FramesSent     (FramesSent)
  );

  always #5 clk = ~clk;

  // Frame buffer model: frames stored back to back, read pointer rewinds to
  // the start of the frame being read; a frame is committed once the next one starts.
  logic [15:0] mem [0:511];
  int wr_cnt = 0;
  int rd_ptr = 0;
  int fbase  = 0;
  int eff_base;

  always_comb begin
    eff_base   = (rd_ptr - fbase == 8) ? rd_ptr : fbase;
    FrameReady = (wr_cnt - eff_base) >= 8;
    DataReady  = wr_cnt > rd_ptr;
  end

  always @(posedge clk) begin
    if (rst || DataFrameReset) begin
      rd_ptr <= fbase;
    end else if (DataNext) begin
      if (rd_ptr - fbase == 8) fbase <= rd_ptr;
      rd_ptr <= rd_ptr + 1;
    end
    DataVal <= mem[rd_ptr[8:0]];
  end

  // Reference model and scoreboard state
  logic [7:0] exp_q [$];
  int fss_m      = SYNC_INTERVAL;
  int exp_frames = 0;
  int checks = 0, errors = 0;
  int acc_count = 0, dn_count = 0, dfr_count = 0;
  int cyc = 0, last_dn = -100;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) TxReady = 1'($urandom_range(0, 1));
  endtask

  task automatic add_frame(input int k, input bit counting);
    for (int w = 0; w < 8; w++)
      mem[k * 8 + w] = counting ? 16'h0100 + 16'(w) : 16'($urandom);
    wr_cnt += 8;
  endtask

  // Expected bytes for frame k: optional sync, then nbytes of payload low byte first.
  task automatic expect_frame(input int k, input int nbytes, input bit complete, output bit synced);
    logic [15:0] w;
    synced = 0;
    if (SYNC_INTERVAL != 0 && fss_m >= SYNC_INTERVAL) begin
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h7F);
      fss_m  = 0;
      synced = 1;
    end
    for (int b = 0; b < nbytes; b++) begin
      w = mem[k * 8 + b / 2];
      exp_q.push_back((b % 2) ? w[15:8] : w[7:0]);
    end
    if (complete) begin
      exp_frames++;
      if (fss_m < SYNC_INTERVAL) fss_m++;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 4000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes pending, required 0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_bytes(input int start, input int target);
    int n = 0;
    while (acc_count - start < target && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_bytes_timeout: got %0d bytes, required %0d", acc_count - start, target);
    end
  endtask

  initial begin
    bit s, s2;
    int start;
    rst = 1'b1; Abort = 1'b0; TxReady = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;

    fork
      begin : monitor
        bit       p_valid, p_ready, p_abort, p_rst;
        logic [7:0] p_byte, eb;
        p_valid = 0; p_ready = 0; p_abort = 0; p_rst = 1; p_byte = 0;
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (TxValid && TxReady) begin
              acc_count++;
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_byte: got %02h, required no byte", TxByte);
              end else begin
                eb = exp_q.pop_front();
                check("tx_byte", TxByte, eb);
              end
            end
            if (p_valid && !p_ready && !p_abort && !p_rst) begin
              check("hold_valid", TxValid, 1'b1);
              check("hold_byte", TxByte, p_byte);
            end
            if (DataNext) begin
              check("datanext_gap_ok", (cyc - last_dn) >= SETTLE, 1'b1);
              last_dn = cyc;
              dn_count++;
            end
            if (DataFrameReset) dfr_count++;
          end
          p_valid = TxValid; p_ready = TxReady; p_byte = TxByte;
          p_abort = Abort;   p_rst = rst;
          cyc++;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_txvalid", TxValid, 1'b0);
    check("reset_txbyte", TxByte, 8'h00);
    check("reset_datanext", DataNext, 1'b0);
    check("reset_dfr", DataFrameReset, 1'b0);
    check("reset_busy", Busy, 1'b0);
    check("reset_frames", FramesSent, 16'd0);
    rst = 1'b0;
    tick();

    // One counting frame, preceded by sync; sync byte one cycle after FrameReady.
    dn_count = 0;
    add_frame(0, 1);
    expect_frame(0, 16, 1, s);
    tick();
    check("sync_latency_valid", TxValid, 1'b1);
    check("sync_latency_byte", TxByte, 8'hFF);
    wait_done("frame0");
    check("frames_after_1", FramesSent, 16'(exp_frames));
    check("datanext_count", dn_count, 8);

    // Sixteen more back to back: sync again only before the 17th frame.
    for (int k = 1; k <= 16; k++) begin
      add_frame(k, 0);
      expect_frame(k, 16, 1, s);
    end
    wait_done("burst");
    check("frames_after_17", FramesSent, 16'(exp_frames));

    // Random backpressure.
    rand_ready = 1;
    for (int k = 17; k <= 20; k++) begin
      add_frame(k, 0);
      expect_frame(k, 16, 1, s);
    end
    wait_done("backpressure");
    rand_ready = 0;
    TxReady = 1'b1;
    check("frames_after_random", FramesSent, 16'(exp_frames));

    // Abort after the third word's low byte; frame resent from word 0.
    dfr_count = 0;
    start = acc_count;
    add_frame(21, 0);
    expect_frame(21, 5, 0, s);
    expect_frame(21, 16, 1, s2);
    wait_bytes(start, 5 + (s ? 4 : 0));
    TxReady = 1'b0;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    tick();
    check("frames_during_abort", FramesSent, 16'(exp_frames - 1));
    TxReady = 1'b1;
    wait_done("abort_resend");
    check("abort_dfr_pulses", dfr_count, 1);
    check("frames_after_abort", FramesSent, 16'(exp_frames));

    // Abort coinciding with the final byte acceptance: frame completes.
    dfr_count = 0;
    start = acc_count;
    add_frame(22, 0);
    expect_frame(22, 16, 1, s);
    wait_bytes(start, 15 + (s ? 4 : 0));
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    wait_done("abort_final");
    check("final_abort_dfr", dfr_count, 0);
    check("frames_after_final_abort", FramesSent, 16'(exp_frames));

    // Asynchronous reset mid-frame; next frame must start with sync.
    start = acc_count;
    add_frame(23, 0);
    expect_frame(23, 16, 1, s);
    wait_bytes(start, 8);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_txvalid", TxValid, 1'b0);
    check("async_rst_txbyte", TxByte, 8'h00);
    check("async_rst_datanext", DataNext, 1'b0);
    check("async_rst_dfr", DataFrameReset, 1'b0);
    check("async_rst_busy", Busy, 1'b0);
    check("async_rst_frames", FramesSent, 16'd0);
    exp_q.delete();
    fss_m = SYNC_INTERVAL;
    exp_frames = 0;
    expect_frame(23, 16, 1, s);
    repeat (2) tick();
    rst = 1'b0;
    wait_done("after_reset");
    check("frames_after_reset", FramesSent, 16'(exp_frames));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
